m_access_arbiter: RTL and testbench

Memory-side access arbiter between the two memory download assemblers (reply path and request path) and the single memory access port. Each assembler presents a fully collected 176-bit message with a valid level; this block grants one, holds its message on the memory port until memory signals completion, then returns a one-cycle done pulse to the granted assembler, which releases its buffer. Replies have priority, and a starvation counter guarantees request forward progress.

---
 rtl/m_access_arbiter_if.sv | 30 +++
 rtl/m_access_arbiter.sv | 86 ++++++++
 tb/tb_m_access_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/m_access_arbiter_if.sv
// Bundle between the download assemblers/memory port and m_access_arbiter.
// The master side drives assembler messages and memory completion; the slave side is the arbiter.
interface m_access_arbiter_if;
   logic         v_m_download_rep;
   logic [175:0] m_download_rep_flits;
   logic         v_m_download_req;
   logic [175:0] m_download_req_flits;
   logic         mem_access_done;
   logic         mem_done_access_rep;
   logic         mem_done_access_req;
   logic         v_mem_access;
   logic [175:0] mem_access_flits;
   logic         mem_access_src;
   logic [1:0]   m_arb_state;
   logic         mem_access_err;

   modport master (
      output v_m_download_rep, m_download_rep_flits, v_m_download_req, m_download_req_flits,
             mem_access_done,
      input  mem_done_access_rep, mem_done_access_req, v_mem_access, mem_access_flits,
             mem_access_src, m_arb_state, mem_access_err
   );

   modport slave (
      input  v_m_download_rep, m_download_rep_flits, v_m_download_req, m_download_req_flits,
             mem_access_done,
      output mem_done_access_rep, mem_done_access_req, v_mem_access, mem_access_flits,
             mem_access_src, m_arb_state, mem_access_err
   );
endinterface

// File: rtl/m_access_arbiter.sv
// Reply/request arbiter onto the single memory access port, reply priority with starvation guard.
// Optional BUSY watchdog enabled by defining M_ARB_TIMEOUT_EN.
module m_access_arbiter #(
   parameter int STARVE_MAX     = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input logic              clk,
   input logic              rst,
   m_access_arbiter_if.slave bus
);
   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_BUSY = 2'b01;
   localparam logic [1:0] S_REL  = 2'b10;
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
   localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT_CYCLES - 1);

   if (STARVE_MAX < 1 || STARVE_MAX > 15 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
      $error("m_access_arbiter: parameter out of range");
   end

   logic [1:0]   state;
   logic [3:0]   starve_cnt;
   logic [175:0] flits;
   logic         src;
   logic         any_v;
   logic         pick_req;
   logic         timeout_hit;

   assign any_v    = bus.v_m_download_rep | bus.v_m_download_req;
   assign pick_req = bus.v_m_download_req & (~bus.v_m_download_rep | (starve_cnt == STARVE_LIM));

`ifdef M_ARB_TIMEOUT_EN
   logic [7:0] tmo_cnt;
   logic       err;

   // tmo_cnt counts BUSY cycles already completed, so the last allowed one sees TMO_LAST
   assign timeout_hit = (tmo_cnt == TMO_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt <= '0;
         err     <= 1'b0;
      end else begin
         err <= (state == S_BUSY) & ~bus.mem_access_done & timeout_hit;
         if (state == S_BUSY) tmo_cnt <= tmo_cnt + 8'd1;
         else                 tmo_cnt <= '0;
      end
   end

   assign bus.mem_access_err = err;
`else
   assign timeout_hit        = 1'b0;
   assign bus.mem_access_err = 1'b0;
   logic unused_tmo;
   assign unused_tmo = &TMO_LAST;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         starve_cnt <= '0;
         flits      <= '0;
         src        <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (any_v) begin
               state <= S_BUSY;
               src   <= pick_req;
               flits <= pick_req ? bus.m_download_req_flits : bus.m_download_rep_flits;
               if (pick_req || !bus.v_m_download_req) starve_cnt <= '0;
               else if (starve_cnt != STARVE_LIM)     starve_cnt <= starve_cnt + 4'd1;
            end
            S_BUSY: if (bus.mem_access_done || timeout_hit) state <= S_REL;
            S_REL:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.v_mem_access        = (state == S_BUSY);
   assign bus.mem_done_access_rep = (state == S_REL) & ~src;
   assign bus.mem_done_access_req = (state == S_REL) &  src;
   assign bus.mem_access_flits    = flits;
   assign bus.mem_access_src      = src;
   assign bus.m_arb_state         = state;
endmodule

// File: tb/tb_m_access_arbiter.sv
// Randomized transaction-level bench for m_access_arbiter; the model predicts each grant
// from the assemblers' pending messages and a starvation tally.
module tb_m_access_arbiter;
   localparam int SMAX = 4;
   localparam int TMO  = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   m_access_arbiter_if bus ();

   m_access_arbiter #(.STARVE_MAX(SMAX), .TIMEOUT_CYCLES(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int           n_chk = 0;
   int           n_err = 0;
   int           starve = 0;
   bit           rep_p = 0, req_p = 0;
   logic [175:0] rep_msg = '0, req_msg = '0;
   logic         obs_src;

   task automatic chk(input string tag, input logic [175:0] got, input logic [175:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [175:0] rnd176();
      logic [191:0] t;
      t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      return t[175:0];
   endfunction

   task automatic drive();
      bus.v_m_download_rep     = rep_p;
      bus.m_download_rep_flits = rep_msg;
      bus.v_m_download_req     = req_p;
      bus.m_download_req_flits = req_msg;
   endtask

   // Full access from an IDLE cycle with at least one source pending; BUSY lasts blen cycles.
   task automatic do_access(input int blen, input bit done_in_rel);
      bit           s;
      logic [175:0] m;
      s = req_p && (!rep_p || starve == SMAX);
      m = s ? req_msg : rep_msg;
      if (s)          starve = 0;
      else if (req_p) starve = (starve < SMAX) ? starve + 1 : SMAX;
      else            starve = 0;
      cyc();
      obs_src = bus.mem_access_src;
      chk("grant_v", bus.v_mem_access, 1);
      chk("grant_src", bus.mem_access_src, s);
      chk("grant_flits", bus.mem_access_flits, m);
      chk("grant_state", bus.m_arb_state, 2'b01);
      for (int i = 1; i < blen; i++) begin
         cyc();
         chk("hold_v", bus.v_mem_access, 1);
         chk("hold_src", bus.mem_access_src, s);
         chk("hold_flits", bus.mem_access_flits, m);
      end
      bus.mem_access_done = 1'b1;
      cyc();
      bus.mem_access_done = done_in_rel;
      chk("rel_state", bus.m_arb_state, 2'b10);
      chk("rel_v", bus.v_mem_access, 0);
      chk("rel_done_rep", bus.mem_done_access_rep, !s);
      chk("rel_done_req", bus.mem_done_access_req, s);
      chk("rel_err", bus.mem_access_err, 0);
      cyc();
      bus.mem_access_done = 1'b0;
      chk("idle_state", bus.m_arb_state, 2'b00);
      chk("idle_pulses", {bus.mem_done_access_rep, bus.mem_done_access_req}, 2'b00);
      if (s) req_p = 0;
      else   rep_p = 0;
      drive();
   endtask

   initial begin
      rst = 1'b1;
      bus.mem_access_done = 1'b0;
      drive();
      cyc();
      cyc();
      chk("rst_state", bus.m_arb_state, 2'b00);
      chk("rst_v", bus.v_mem_access, 0);
      chk("rst_flits", bus.mem_access_flits, 0);
      chk("rst_src", bus.mem_access_src, 0);
      chk("rst_pulses", {bus.mem_done_access_rep, bus.mem_done_access_req, bus.mem_access_err}, 0);
      rst = 1'b0;
      cyc();

      // reply with the fixed pattern, done after 4 BUSY cycles
      rep_msg = {11{16'h1234}};
      rep_p   = 1;
      drive();
      do_access(4, 0);

      // request only
      req_msg = rnd176();
      req_p   = 1;
      drive();
      do_access(2, 1);

      // completion strobe while IDLE is ignored
      bus.mem_access_done = 1'b1;
      cyc();
      bus.mem_access_done = 1'b0;
      chk("idle_done_state", bus.m_arb_state, 2'b00);
      chk("idle_done_pulses", {bus.v_mem_access, bus.mem_done_access_rep, bus.mem_done_access_req}, 0);

      // starvation: reply keeps re-asserting, request must win the 5th arbitration
      req_msg = rnd176();
      req_p   = 1;
      for (int k = 0; k < 5; k++) begin
         rep_msg = rnd176();
         rep_p   = 1;
         drive();
         do_access(1, k[0]);
         chk(k < 4 ? "starve_rep_first" : "starve_req_5th", obs_src, k < 4 ? 0 : 1);
      end

      // reset mid-BUSY: outputs drop immediately, pending reply is regranted afterwards
      cyc();
      chk("pre_rst_v", bus.v_mem_access, 1);
      #1 rst = 1'b1;
      #1;
      chk("arst_v", bus.v_mem_access, 0);
      chk("arst_state", bus.m_arb_state, 2'b00);
      chk("arst_flits", bus.mem_access_flits, 0);
      chk("arst_src", bus.mem_access_src, 0);
      starve = 0;
      cyc();
      rst = 1'b0;
      do_access(3, 0);

      // random traffic
      for (int it = 0; it < 150; it++) begin
         if (!rep_p && $urandom_range(0, 9) < 6) begin rep_p = 1; rep_msg = rnd176(); end
         if (!req_p && $urandom_range(0, 9) < 6) begin req_p = 1; req_msg = rnd176(); end
         drive();
         if (!rep_p && !req_p) begin
            bus.mem_access_done = $urandom_range(0, 1);
            cyc();
            bus.mem_access_done = 1'b0;
            chk("rnd_idle_state", bus.m_arb_state, 2'b00);
            chk("rnd_idle_v", bus.v_mem_access, 0);
         end else begin
            do_access($urandom_range(1, 7), $urandom_range(0, 1));
         end
      end

      // drain anything still pending so the watchdog checks start from a clean IDLE
      while (rep_p || req_p) do_access(1, 0);

`ifdef M_ARB_TIMEOUT_EN
      // silent memory: abort after TMO BUSY cycles with error and done together
      rep_msg = rnd176();
      rep_p   = 1;
      starve  = 0;
      drive();
      cyc();
      chk("tmo_grant_v", bus.v_mem_access, 1);
      for (int i = 1; i < TMO; i++) begin
         cyc();
         chk("tmo_wait_state", bus.m_arb_state, 2'b01);
      end
      cyc();
      chk("tmo_rel_state", bus.m_arb_state, 2'b10);
      chk("tmo_err", bus.mem_access_err, 1);
      chk("tmo_done_rep", bus.mem_done_access_rep, 1);
      cyc();
      chk("tmo_err_clear", bus.mem_access_err, 0);
      rep_p = 0;
      drive();
      // done on the last allowed cycle wins over the timeout
      rep_msg = rnd176();
      rep_p   = 1;
      drive();
      do_access(TMO, 0);
`else
      // without the watchdog BUSY waits as long as memory takes
      rep_msg = rnd176();
      rep_p   = 1;
      drive();
      do_access(TMO + 20, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
